// File: rtl/sipo_rx_pkg.sv
// sipo_rx_pkg: shared types, constants and helpers for the sipo_rx receiver.
//   sipo_state_e   : receiver FSM state (IDLE / SHIFT)
//   SIPO_MSB_FIRST : left_right value selecting MSB-first order
//   SIPO_LSB_FIRST : left_right value selecting LSB-first order
//   frame_len(dw)  : serial bits per frame (dw, or dw+1 when SIPO_RX_PARITY_EN is defined)
package sipo_rx_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sipo_state_e;

  localparam logic SIPO_MSB_FIRST = 1'b0;
  localparam logic SIPO_LSB_FIRST = 1'b1;

  // Number of serial samples in one frame, including the optional parity bit.
  function automatic int frame_len(input int dw);
`ifdef SIPO_RX_PARITY_EN
    return dw + 32'sd1;
`else
    return dw;
`endif
  endfunction

endpackage

// File: rtl/sipo_bit_cnt.sv
// sipo_bit_cnt: bit counter for the sipo_rx frame assembler.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clr      : restart the count; with en also high the current cycle counts as the first (cnt=1)
//   en       : count one sample
//   cnt      : current count (registered)
//   tc       : high while cnt equals TC
module sipo_bit_cnt #(
  parameter int W  = 3,
  parameter int TC = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] ONE    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] TC_VAL = W'(TC);

  logic [W-1:0] cnt_r;

  // Count register: clear has priority so a restart and a completion never keep a stale count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else if (clr) begin
      cnt_r <= en ? ONE : {W{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;
  assign tc  = (cnt_r == TC_VAL);

endmodule

// File: rtl/sipo_rx.sv
// sipo_rx: serial-in/parallel-out receiver with valid/ready output and overrun flag.
// Optional feature macro: SIPO_RX_PARITY_EN (adds an even-parity bit per frame and parity_err).
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   enb        : bit-sample enable
//   sin        : serial data in
//   start      : first bit of a word (qualified by enb); restarts a partial word
//   left_right : bit order latched with start (0 MSB first, 1 LSB first)
//   out_ready  : consumer accepts data when out_valid is high
//   ovr_clr    : clears overrun (a simultaneous new overrun wins)
//   data       : last completed word (registered)
//   out_valid  : data holds an unaccepted word
//   busy       : a word is being assembled
//   overrun    : sticky, a completed word was dropped
//   parity_err : (parity build only) parity check result loaded with data
module sipo_rx
  import sipo_rx_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enb,
  input  logic          sin,
  input  logic          start,
  input  logic          left_right,
  input  logic          out_ready,
  input  logic          ovr_clr,
  output logic [DW-1:0] data,
  output logic          out_valid,
  output logic          busy,
  output logic          overrun
`ifdef SIPO_RX_PARITY_EN
  ,
  output logic          parity_err
`endif
);

  localparam int FL = frame_len(DW);
  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] DW_IDX = CW'(DW);

`ifdef SIPO_RX_PARITY_EN
  // Even parity: the data bits XOR the parity bit must be zero.
  function automatic logic even_parity_err(input logic [DW-1:0] w, input logic p);
    return (^w) ^ p;
  endfunction
`endif

  sipo_state_e   state_r;
  sipo_state_e   state_nxt_s;

  logic [DW-1:0] sreg_r;
  logic [DW-1:0] next_sreg_s;
  logic [DW-1:0] word_s;
  logic [DW-1:0] data_r;
  logic          lr_r;
  logic          valid_r;
  logic          ovr_r;
  logic          order_s;

  logic          frame_start_s;
  logic          sample_s;
  logic          data_bit_s;
  logic          complete_s;
  logic          cnt_clr_s;
  logic          cnt_en_s;
  logic          load_s;
  logic          drop_s;
  logic [CW-1:0] cnt_s;
  logic          last_s;

  assign frame_start_s = enb & start;

  sipo_bit_cnt #(
    .W  (CW),
    .TC (FL - 1)
  ) u_bit_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr_s),
    .en  (cnt_en_s),
    .cnt (cnt_s),
    .tc  (last_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: a qualified start always (re)enters SHIFT, even on the final-bit cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (frame_start_s) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (frame_start_s) begin
          state_nxt_s = SHIFT;
        end else if (enb && last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM outputs: sample strobe, completion strobe and counter control.
  always_comb begin
    sample_s   = 1'b0;
    complete_s = 1'b0;
    cnt_clr_s  = 1'b0;
    cnt_en_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (frame_start_s) begin
          sample_s  = 1'b1;
          cnt_clr_s = 1'b1;
          cnt_en_s  = 1'b1;
        end else begin
          sample_s  = 1'b0;
        end
      end
      SHIFT: begin
        if (frame_start_s) begin
          sample_s  = 1'b1;
          cnt_clr_s = 1'b1;
          cnt_en_s  = 1'b1;
        end else if (enb && last_s) begin
          sample_s   = 1'b1;
          complete_s = 1'b1;
          cnt_clr_s  = 1'b1;
        end else if (enb) begin
          sample_s = 1'b1;
          cnt_en_s = 1'b1;
        end else begin
          sample_s = 1'b0;
        end
      end
      default: begin
        sample_s = 1'b0;
      end
    endcase
  end

  // The bit order of the current sample comes straight from left_right on a start cycle.
  assign order_s     = frame_start_s ? left_right : lr_r;
  assign next_sreg_s = (order_s == SIPO_LSB_FIRST) ? {sin, sreg_r[DW-1:1]}
                                                   : {sreg_r[DW-2:0], sin};
  // The parity sample (index DW) is not a data bit and leaves the shift register alone.
  assign data_bit_s  = sample_s & (frame_start_s | (cnt_s < DW_IDX));

`ifdef SIPO_RX_PARITY_EN
  assign word_s = sreg_r;
`else
  assign word_s = next_sreg_s;
`endif

  assign load_s = complete_s & (~valid_r | out_ready);
  assign drop_s = complete_s & valid_r & ~out_ready;

  // Datapath: shift register, latched order, output word, handshake and overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_r  <= {DW{1'b0}};
      lr_r    <= 1'b0;
      data_r  <= {DW{1'b0}};
      valid_r <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      if (data_bit_s) begin
        sreg_r <= next_sreg_s;
      end else begin
        sreg_r <= sreg_r;
      end
      if (frame_start_s) begin
        lr_r <= left_right;
      end else begin
        lr_r <= lr_r;
      end
      if (load_s) begin
        data_r <= word_s;
      end else begin
        data_r <= data_r;
      end
      if (load_s) begin
        valid_r <= 1'b1;
      end else if (out_ready) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
      // A new drop beats a clear on the same cycle.
      if (drop_s) begin
        ovr_r <= 1'b1;
      end else if (ovr_clr) begin
        ovr_r <= 1'b0;
      end else begin
        ovr_r <= ovr_r;
      end
    end
  end

`ifdef SIPO_RX_PARITY_EN
  logic perr_r;

  // Parity result travels with data; a dropped word leaves it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      perr_r <= 1'b0;
    end else if (load_s) begin
      perr_r <= even_parity_err(sreg_r, sin);
    end else begin
      perr_r <= perr_r;
    end
  end

  assign parity_err = perr_r;
`endif

  assign data      = data_r;
  assign out_valid = valid_r;
  assign overrun   = ovr_r;
  assign busy      = (state_r == SHIFT);

endmodule

// File: tb/tb_sipo_rx.sv
// tb_sipo_rx: randomized + directed bench for sipo_rx with a frame-level reference model
// and a scoreboard of accepted words. Works with or without SIPO_RX_PARITY_EN.
module tb_sipo_rx;
  import sipo_rx_pkg::*;

  localparam int DW = 4;
  localparam int FL = frame_len(DW);

  logic          clk = 1'b0;
  logic          rst, enb, sin, start, left_right, out_ready, ovr_clr;
  logic [DW-1:0] data;
  logic          out_valid, busy, overrun;
`ifdef SIPO_RX_PARITY_EN
  logic          parity_err;
`endif

  sipo_rx #(.DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .enb        (enb),
    .sin        (sin),
    .start      (start),
    .left_right (left_right),
    .out_ready  (out_ready),
    .ovr_clr    (ovr_clr),
    .data       (data),
    .out_valid  (out_valid),
    .busy       (busy),
    .overrun    (overrun)
`ifdef SIPO_RX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, enb, sin, start, lr, ready, clr;
  } stim_t;

  typedef struct {
    logic [DW-1:0] w;
    logic          perr;
  } exp_t;

  stim_t sq[$];
  exp_t  exp_q[$];

  int checks = 0;
  int errors = 0;

  // reference model state
  logic m_valid = 1'b0, m_ovr = 1'b0, m_busy = 1'b0, m_lr = 1'b0, m_par = 1'b0;
  logic m_rst_chk = 1'b0;
  logic started = 1'b0;
  int   m_idx = 0;
  logic m_bits [DW];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic r, input logic e, input logic s, input logic st,
                      input logic lr, input logic rd, input logic cl);
    stim_t t;
    t.rst = r; t.enb = e; t.sin = s; t.start = st; t.lr = lr; t.ready = rd; t.clr = cl;
    sq.push_back(t);
  endtask

  // rmode: 0 never ready, 1 always ready, 2 random ready/clear, 3 ready only on the last bit
  function automatic logic rdy(input int rmode, input logic last);
    case (rmode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return 1'($urandom_range(0, 1));
      default: return last;
    endcase
  endfunction

  function automatic logic rclr(input int rmode);
    return (rmode == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
  endfunction

  task automatic idle(input int n, input int rmode);
    for (int i = 0; i < n; i++)
      push(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
           1'($urandom_range(0, 1)), rdy(rmode, 1'b0), rclr(rmode));
  endtask

  // Send the first nbits of a word, preceded/separated by up to maxgap disabled cycles.
  task automatic send_bits(input logic [DW-1:0] w, input logic lr, input logic bad_par,
                           input int nbits, input int maxgap, input int rmode);
    logic b;
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) begin
        int g = $urandom_range(0, maxgap);
        for (int k = 0; k < g; k++)
          push(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), rdy(rmode, 1'b0), rclr(rmode));
      end
      if (i < DW) b = lr ? w[i] : w[DW-1-i];
      else        b = (^w) ^ bad_par;
      push(1'b0, 1'b1, b, (i == 0), lr, rdy(rmode, (i == FL - 1)), rclr(rmode));
    end
  endtask

  task automatic add_frame(input logic [DW-1:0] w, input logic lr, input logic bad_par,
                           input int maxgap, input int rmode);
    send_bits(w, lr, bad_par, FL, maxgap, rmode);
  endtask

  // Reference model: one clock edge with stimulus s applied.
  task automatic model_step(input stim_t s);
    logic [DW-1:0] w;
    logic done, dropped;
    exp_t e;
    done = 1'b0;
    dropped = 1'b0;
    m_rst_chk = 1'b0;
    if (s.rst) begin
      m_valid = 1'b0; m_ovr = 1'b0; m_busy = 1'b0; m_idx = 0;
      exp_q.delete();
      m_rst_chk = 1'b1;
      return;
    end
    if (s.enb && s.start) begin
      m_busy = 1'b1; m_lr = s.lr; m_bits[0] = s.sin; m_idx = 1;
    end else if (s.enb && m_busy) begin
      if (m_idx < DW) m_bits[m_idx] = s.sin;
      else            m_par = s.sin;
      m_idx++;
      if (m_idx == FL) begin
        done = 1'b1; m_busy = 1'b0; m_idx = 0;
      end
    end
    if (done) begin
      w = '0;
      for (int i = 0; i < DW; i++)
        if (m_bits[i]) w = w + (DW'(1) << (m_lr ? i : DW - 1 - i));
      if (!m_valid || s.ready) begin
        e.w = w;
        e.perr = (^w) ^ m_par;
        exp_q.push_back(e);
        m_valid = 1'b1;
      end else begin
        dropped = 1'b1;
      end
    end else if (m_valid && s.ready) begin
      m_valid = 1'b0;
    end
    if (dropped) m_ovr = 1'b1;
    else if (s.clr) m_ovr = 1'b0;
  endtask

  // Monitor: status flags every cycle, scoreboard pop on each accepted word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (started) begin
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (m_rst_chk) chk("data_after_reset", 32'(data), 32'd0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 32'(data), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("data", 32'(data), 32'(e.w));
`ifdef SIPO_RX_PARITY_EN
            chk("parity_err", 32'(parity_err), 32'(e.perr));
`endif
          end
        end
      end
    end
  end

  initial begin
    stim_t cur;
    rst = 1'b1; enb = 1'b0; sin = 1'b0; start = 1'b0;
    left_right = 1'b0; out_ready = 1'b0; ovr_clr = 1'b0;

    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2, 1);
    // MSB first, LSB first, enb stalls, loopback word from upstream shifter
    add_frame(4'b1011, SIPO_MSB_FIRST, 1'b0, 0, 1); idle(2, 1);
    add_frame(4'b1011, SIPO_LSB_FIRST, 1'b0, 0, 1); idle(2, 1);
    add_frame(4'b1011, SIPO_MSB_FIRST, 1'b0, 3, 1); idle(2, 1);
    add_frame(4'hA,    SIPO_MSB_FIRST, 1'b0, 0, 1); idle(2, 1);
    // backpressure: 3 held, C dropped, clear, 5 accepted on its completion cycle
    add_frame(4'h3, SIPO_MSB_FIRST, 1'b0, 0, 0);
    add_frame(4'hC, SIPO_MSB_FIRST, 1'b0, 0, 0);
    idle(1, 0);
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1, 0);
    add_frame(4'h5, SIPO_MSB_FIRST, 1'b0, 0, 3);
    idle(3, 1);
    // restart after two bits
    send_bits(4'b1001, SIPO_MSB_FIRST, 1'b0, 2, 0, 1);
    add_frame(4'b0110, SIPO_MSB_FIRST, 1'b0, 0, 1); idle(2, 1);
    // reset at bit 2 with a pending word and an overrun outstanding
    add_frame(4'h9, SIPO_MSB_FIRST, 1'b0, 0, 0);
    add_frame(4'h6, SIPO_MSB_FIRST, 1'b0, 0, 0);
    send_bits(4'hF, SIPO_MSB_FIRST, 1'b0, 2, 0, 0);
    push(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2, 1);
    // parity good / bad (plain data frames in the default build)
    add_frame(4'b1011, SIPO_MSB_FIRST, 1'b0, 0, 1); idle(1, 1);
    add_frame(4'b1011, SIPO_MSB_FIRST, 1'b1, 0, 1); idle(1, 1);
    // random traffic: back-to-back frames, stalls, restarts, random backpressure
    for (int f = 0; f < 80; f++) begin
      if ($urandom_range(0, 4) == 0)
        send_bits(DW'($urandom), 1'($urandom_range(0, 1)), 1'b0,
                  $urandom_range(1, FL - 1), 1, 2);
      add_frame(DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), 2);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3), 2);
    end
    idle(8, 1);

    while (sq.size() > 0) begin
      cur = sq.pop_front();
      rst = cur.rst; enb = cur.enb; sin = cur.sin; start = cur.start;
      left_right = cur.lr; out_ready = cur.ready; ovr_clr = cur.clr;
      @(posedge clk);
      model_step(cur);
      started = 1'b1;
      #1;
    end
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in/parallel-out receiver that sits directly downstream of the team's parallel-to-serial shift stage. It consumes the serial bit stream, optionally gated by an enable, and reassembles `DW`-bit words in either MSB-first or LSB-first order. Completed words are presented on a registered parallel port with a valid/ready handshake. Overrun is flagged when the consumer stalls.

## Interface
- `DW`, default 4: word width in bits; must be at least 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `enb` input 1: bit-sample enable; `sin` is sampled only on cycles with `enb`=1.
- `sin` input 1: serial data in.
- `start` input 1: qualified by `enb`; marks the cycle that carries the first bit of a word.
- `left_right` input 1: bit order, sampled with `start`. 0 = MSB first; 1 = LSB first.
- `out_ready` input 1: consumer accepts `data` when `out_ready`=1 and `out_valid`=1.
- `ovr_clr` input 1: clears `overrun`.
- `data` output DW: last completed word; register held stable while `out_valid`=1.
- `out_valid` output 1: `data` holds an unaccepted word.
- `busy` output 1: a word is being assembled (state SHIFT).
- `overrun` output 1: sticky flag; a completed word was dropped.

## Operation
- Reset values: `data`=0, `out_valid`=0, `busy`=0, `overrun`=0, shift register=0, bit counter=0, state IDLE.
- States:
  - IDLE: when `enb`=1 and `start`=1, the receiver samples `sin` as bit 0, latches `left_right`, sets cnt=1 and moves to SHIFT.
  - SHIFT: each cycle with `enb`=1 samples one bit and increments cnt. Cycles with `enb`=0 hold all state.
  - Frame completion: when the sampled bit is the final bit (cnt=DW-1 on that cycle), the receiver performs the completion action and returns to IDLE. `DW`=2 is legal.
- Shift rules:
  - MSB first: `sreg <= {sreg[DW-2:0], sin}`.
  - LSB first: `sreg <= {sin, sreg[DW-1:1]}`.
  - After DW samples, the first bit received sits at bit DW-1 (MSB first) or bit 0 (LSB first).
- Completion action:
  - If `out_valid`=0, or `out_valid`=1 and `out_ready`=1 on the same cycle: `data` is loaded with the assembled word and `out_valid` stays or goes to 1.
  - Otherwise the new word is dropped, `data` keeps the old word and `overrun` is set.
- Handshake: `out_valid` falls the cycle after acceptance, unless a completion on the acceptance cycle reloads `data`.
- Restart: `start`=1 with `enb`=1 while in SHIFT aborts the partial word. That cycle's bit becomes bit 0 of a new word, cnt=1, and `left_right` is re-latched. Nothing is emitted for the aborted word.
- `overrun` clearing:
  - `ovr_clr`=1 clears `overrun`.
  - If `ovr_clr` and a new overrun occur on the same cycle, set wins.
- Reset mid-frame discards the partial word and any pending `data`.
- Counter width: `$clog2(DW+1)` bits. No wrap occurs, because the counter clears on completion.

## Timing
- `out_valid` asserts on the rising edge that samples the final bit. It is visible the cycle after the last `sin` is presented.
- Minimum word period is DW `enb` cycles. Back-to-back words, with `start` on the cycle after the last bit, are supported with no gap.
- `busy` is high from the edge after `start` is sampled until the completion edge.
- `data`, `out_valid`, `busy` and `overrun` are all registered outputs; no input-to-output combinational path.

## Configuration
- `SIPO_RX_PARITY_EN` defined:
  - Each word is followed by one even-parity bit, sampled as bit index DW, so completion occurs at cnt=DW.
  - An extra output `parity_err` (1 bit, reset 0) is loaded together with `data`. It is 1 when the XOR of the data bits and the parity bit is 1.
  - A dropped word does not update `parity_err`.
- `SIPO_RX_PARITY_EN` undefined: no parity bit, no `parity_err` port; frame length is DW.

## Structure
- `sipo_rx_pkg` holds:
  - state typedef `sipo_state_e` (IDLE, SHIFT);
  - constants `SIPO_MSB_FIRST`=1'b0 and `SIPO_LSB_FIRST`=1'b1;
  - function `frame_len(DW)` returning DW, or DW+1 with parity.
- One sub-module, `sipo_bit_cnt`: parameterized counter with clear, enable and terminal-count output. It is instantiated once in `sipo_rx`.

## Test plan
All scenarios use DW=4 unless stated.
- MSB first: `start` with `sin`=1, then 0,1,1 on consecutive `enb` cycles -> `data`=4'b1011, `out_valid`=1 the next cycle, `busy` low.
- LSB first: `left_right`=1, `sin` sequence 1,1,0,1 -> `data`=4'b1011.
- `enb` gaps:
  - Stall insertion: same MSB-first stream with `enb`=0 cycles inserted between bits -> identical 4'b1011; `out_valid` delayed exactly by the stall count.
  - Loopback: connect the upstream shift stage's serial output with load 4'hA -> `data`=4'hA.
- Backpressure:
  - Setup: `out_ready`=0, then two words 4'h3 and 4'hC are sent.
  - Required: `data` stays 4'h3 and `overrun`=1.
  - Clear: `ovr_clr` pulse -> `overrun`=0.
  - Acceptance on completion: `out_ready`=1 on the completion cycle of a third word 4'h5 -> `data`=4'h5 with no overrun.
- Restart: `start` reasserted after 2 bits, then 0,1,1,0 -> `data`=4'b0110 and exactly one `out_valid` pulse.
- Reset: `rst` asserted at bit 2 -> all outputs 0.
- Parity (with `SIPO_RX_PARITY_EN`):
  - 4'b1011 followed by parity 1 -> `parity_err`=0.
  - 4'b1011 followed by parity 0 -> `parity_err`=1.
